// File: rtl/sync_fifo_param.sv
// Single-clock FIFO on inferred RAM with selectable first-word-fall-through or
// registered-read output, threshold flags, occupancy count and error pulses.
module sync_fifo_param #(
  parameter int WIDTH               = 36,
  parameter int DEPTH_LOG2          = 9,
  parameter int FWFT                = 1,
  parameter int ALMOST_FULL_OFFSET  = 128,
  parameter int ALMOST_EMPTY_OFFSET = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      writeData,
  input  logic                  writeEnable,
  output logic                  full,
  output logic                  almostFull,
  output logic                  writeError,
  output logic [WIDTH-1:0]      readData,
  input  logic                  readEnable,
  output logic                  empty,
  output logic                  almostEmpty,
  output logic                  readError,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_LVL   = CW'(DEPTH - ALMOST_FULL_OFFSET);
  localparam logic [CW-1:0]         AE_LVL   = CW'(ALMOST_EMPTY_OFFSET);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  if (DEPTH_LOG2 < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH_LOG2 must be at least 2");
  end
  if (ALMOST_FULL_OFFSET >= DEPTH) begin : g_bad_af
    $error("sync_fifo_param: ALMOST_FULL_OFFSET must be below DEPTH");
  end
  if (ALMOST_EMPTY_OFFSET >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: ALMOST_EMPTY_OFFSET must be below DEPTH");
  end

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, r_ram_cnt;
  logic [WIDTH-1:0]      r_ram_q_p1, r_rdata_p2;
  logic                  r_vld_p1;
  logic                  r_empty, r_full, r_afull, r_aempty, r_werr, r_rerr;

  logic                  w_wr_acc, w_rd_acc, w_fetch, w_adv;
  logic                  w_empty_nxt, w_vld_p1_nxt;
  logic [CW-1:0]         w_count_nxt, w_ram_cnt_nxt;

  // In FWFT mode the output register is refilled from the RAM-read stage
  // whenever it is free or being popped; r_ram_cnt tracks words still in RAM.
  always_comb begin
    w_wr_acc     = writeEnable && !r_full;
    w_rd_acc     = readEnable && !r_empty;
    w_count_nxt  = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    w_adv        = r_vld_p1;
    w_fetch      = w_rd_acc;
    w_empty_nxt  = (w_count_nxt - CW'(w_wr_acc)) == '0;
    if (FWFT != 0) begin
      w_adv       = r_vld_p1 && (r_empty || w_rd_acc);
      w_fetch     = (r_ram_cnt != '0) && (!r_vld_p1 || w_adv);
      w_empty_nxt = !(w_adv || (!r_empty && !w_rd_acc));
    end
    w_ram_cnt_nxt = r_ram_cnt + CW'(w_wr_acc) - CW'(w_fetch);
    w_vld_p1_nxt  = w_fetch || (r_vld_p1 && !w_adv);
  end

  // p0 -> p1: storage write and RAM read register
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= writeData;
    if (w_fetch)  r_ram_q_p1 <= r_mem[r_rd_ptr];
  end

  // p1 -> p2: output register, pointers, occupancy and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ram_cnt  <= '0;
      r_vld_p1   <= 1'b0;
      r_empty    <= 1'b1;
      r_aempty   <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_werr     <= 1'b0;
      r_rerr     <= 1'b0;
      r_rdata_p2 <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_fetch)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_adv)    r_rdata_p2 <= r_ram_q_p1;
      r_count    <= w_count_nxt;
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_vld_p1   <= w_vld_p1_nxt;
      r_empty    <= w_empty_nxt;
      r_full     <= (w_count_nxt == FULL_LVL);
      r_afull    <= (w_count_nxt >= AF_LVL);
      r_aempty   <= (w_count_nxt <= AE_LVL);
      r_werr     <= writeEnable && r_full;
      r_rerr     <= readEnable && r_empty;
    end
  end

  assign full        = r_full;
  assign almostFull  = r_afull;
  assign writeError  = r_werr;
  assign readData    = r_rdata_p2;
  assign empty       = r_empty;
  assign almostEmpty = r_aempty;
  assign readError   = r_rerr;
  assign count       = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised bench for sync_fifo_param: an FWFT and a standard-mode instance,
// each compared cycle by cycle against a queue-based occupancy/latency model.
module tb_sync_fifo_param;

  localparam int W   = 36;
  localparam int DL  = 4;
  localparam int D   = 16;
  localparam int AFO = 4;
  localparam int AEO = 3;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] wd_f, wd_s, rd_f, rd_s;
  logic we_f, re_f, we_s, re_s;
  logic full_f, af_f, werr_f, empty_f, ae_f, rerr_f;
  logic full_s, af_s, werr_s, empty_s, ae_s, rerr_s;
  logic [DL:0] cnt_f, cnt_s;

  sync_fifo_param #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(1),
                    .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO)) u_fwft (
    .clk(clk), .reset(rst), .writeData(wd_f), .writeEnable(we_f),
    .full(full_f), .almostFull(af_f), .writeError(werr_f),
    .readData(rd_f), .readEnable(re_f), .empty(empty_f),
    .almostEmpty(ae_f), .readError(rerr_f), .count(cnt_f));

  sync_fifo_param #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(0),
                    .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO)) u_std (
    .clk(clk), .reset(rst), .writeData(wd_s), .writeEnable(we_s),
    .full(full_s), .almostFull(af_s), .writeError(werr_s),
    .readData(rd_s), .readEnable(re_s), .empty(empty_s),
    .almostEmpty(ae_s), .readError(rerr_s), .count(cnt_s));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of words tagged with the edge they were written.
  // The head becomes visible to the reader a fixed number of edges after its
  // write (2 in FWFT mode, 1 in standard mode); count is the queue size.
  typedef struct {
    logic [W-1:0] d;
    int           e;
  } ent_t;

  ent_t         q[$];
  int           mode;
  int           ecnt = 0;
  logic         m_empty, m_full, m_werr, m_rerr, pend_vld;
  logic [W-1:0] m_rd, pend;

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    q.delete();
    m_empty  = 1'b1;
    m_full   = 1'b0;
    m_werr   = 1'b0;
    m_rerr   = 1'b0;
    m_rd     = '0;
    pend     = '0;
    pend_vld = 1'b0;
  endtask

  task automatic compare(input string ph);
    logic [W-1:0] rd;
    logic [DL:0]  cnt;
    logic         fl, af, we, em, ae, re;
    if (mode == 1) begin
      rd = rd_f; cnt = cnt_f; fl = full_f; af = af_f; we = werr_f;
      em = empty_f; ae = ae_f; re = rerr_f;
    end else begin
      rd = rd_s; cnt = cnt_s; fl = full_s; af = af_s; we = werr_s;
      em = empty_s; ae = ae_s; re = rerr_s;
    end
    chk({ph, ".count"},       64'(cnt), 64'(q.size()));
    chk({ph, ".full"},        64'(fl),  64'(m_full));
    chk({ph, ".almostFull"},  64'(af),  64'(q.size() >= D - AFO));
    chk({ph, ".almostEmpty"}, 64'(ae),  64'(q.size() <= AEO));
    chk({ph, ".empty"},       64'(em),  64'(m_empty));
    chk({ph, ".writeError"},  64'(we),  64'(m_werr));
    chk({ph, ".readError"},   64'(re),  64'(m_rerr));
    chk({ph, ".readData"},    64'(rd),  64'(m_rd));
  endtask

  task automatic cyc(input logic we, input logic re, input logic [W-1:0] wd, input string ph);
    ent_t en;
    int   lat;
    logic wacc, racc;
    if (mode == 1) begin
      we_f = we; re_f = re; wd_f = wd;
    end else begin
      we_s = we; re_s = re; wd_s = wd;
    end
    @(posedge clk);
    ecnt++;
    wacc   = we && !m_full;
    racc   = re && !m_empty;
    m_werr = we && m_full;
    m_rerr = re && m_empty;
    if (pend_vld) begin
      m_rd     = pend;
      pend_vld = 1'b0;
    end
    if (racc) begin
      en = q.pop_front();
      if (mode == 0) begin
        pend     = en.d;
        pend_vld = 1'b1;
      end
    end
    if (wacc) begin
      en.d = wd;
      en.e = ecnt;
      q.push_back(en);
    end
    m_full = (q.size() == D);
    lat    = (mode == 1) ? 2 : 1;
    if (q.size() == 0) m_empty = 1'b1;
    else               m_empty = (q[0].e + lat > ecnt);
    if (mode == 1 && !m_empty) m_rd = q[0].d;
    #1;
    compare(ph);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    we_f = 1'b0; re_f = 1'b0; we_s = 1'b0; re_s = 1'b0;
    @(posedge clk);
    ecnt++;
    model_reset();
    #1;
    compare("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    we_f = 1'b0; re_f = 1'b0; wd_f = '0;
    we_s = 1'b0; re_s = 1'b0; wd_s = '0;
    model_reset();
    for (int m = 1; m >= 0; m--) begin
      mode = m;
      do_reset();
      repeat (5) cyc(1'b0, 1'b0, '0, "idle");

      cyc(1'b1, 1'b0, W'(36'h000000ABC), "wr_abc");
      repeat (2) cyc(1'b0, 1'b0, '0, "abc_lat");
      cyc(1'b0, 1'b1, '0, "pop_abc");
      repeat (2) cyc(1'b0, 1'b0, '0, "after_pop");

      for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, W'(i), "fill");
      cyc(1'b1, 1'b0, W'(16), "overflow");
      repeat (2) cyc(1'b0, 1'b0, '0, "full_idle");
      cyc(1'b1, 1'b1, W'(99), "full_rw");
      repeat (D + 3) cyc(1'b0, 1'b1, '0, "drain");
      cyc(1'b0, 1'b1, '0, "underflow");
      cyc(1'b0, 1'b0, '0, "uf_idle");

      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, rnd(), "pre_steady");
      repeat (3) cyc(1'b0, 1'b0, '0, "settle");
      repeat (100) cyc(1'b1, 1'b1, rnd(), "steady");

      repeat (150) cyc(1'(($urandom() % 4) != 0), 1'($urandom() % 2), rnd(), "rand_up");
      repeat (150) cyc(1'($urandom() % 2), 1'(($urandom() % 4) != 0), rnd(), "rand_dn");

      repeat (20) cyc(1'b0, 1'b1, '0, "clear");
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, W'(i + 32), "pre_reset");
      repeat (3) cyc(1'b0, 1'b0, '0, "pre_reset_idle");
      do_reset();
      cyc(1'b1, 1'b0, W'(7), "post_reset_wr");
      repeat (3) cyc(1'b0, 1'b0, '0, "post_reset_idle");
      cyc(1'b0, 1'b1, '0, "post_reset_rd");
      repeat (2) cyc(1'b0, 1'b0, '0, "post_reset_end");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's fixed 36-bit async FIFO primitive wrapper.
- Inferred-RAM FIFO with selectable first-word-fall-through (FWFT) or standard read mode, programmable almost-full/almost-empty thresholds, occupancy count, and sticky-free overflow/underflow error pulses.
- Used inside single-domain datapaths (PUF response buffering, host I/O staging) where a clock-crossing primitive is unnecessary.

Parameters:
- WIDTH, 36, data word width in bits (1..1024).
- DEPTH_LOG2, 9, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 words.
- FWFT, 1, 1 = first-word-fall-through read mode; 0 = standard registered-read mode.
- ALMOST_FULL_OFFSET, 128, almostFull asserts when count >= DEPTH - ALMOST_FULL_OFFSET.
- ALMOST_EMPTY_OFFSET, 128, almostEmpty asserts when count <= ALMOST_EMPTY_OFFSET.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- writeData  input  WIDTH  write data.
- writeEnable  input  1  write request.
- full  output  1  count == DEPTH; writes are rejected.
- almostFull  output  1  threshold flag (see parameters).
- writeError  output  1  one-cycle pulse: the previous cycle's write was rejected.
- readData  output  WIDTH  read data.
- readEnable  input  1  read request (FWFT: acknowledge/pop of the presented word).
- empty  output  1  no word available to the reader.
- almostEmpty  output  1  threshold flag.
- readError  output  1  one-cycle pulse: the previous cycle's read was rejected.
- count  output  DEPTH_LOG2+1  words accepted and not yet read (0..DEPTH).

Behaviour:
- Reset: synchronous and active-high; takes priority over all other inputs.
  - Pointers and count cleared to 0; stored contents discarded.
  - empty=1, almostEmpty=1, full=0, almostFull=0, writeError=0, readError=0, readData=0.
  - Reset mid-operation behaves identically; the first post-reset write is treated as a write into an empty FIFO.
- Write acceptance: at an edge, a write is accepted when writeEnable=1 and full=0 (registered value).
  - Accepted: the word is stored and the write pointer increments modulo DEPTH.
  - Rejected: storage is untouched and writeError=1 for exactly the next cycle.
- Read acceptance: at an edge, a read is accepted when readEnable=1 and empty=0.
  - Rejected: readError=1 for the next cycle; no pointer, data or count change.
- count:
  - +1 on accepted write only; -1 on accepted read only.
  - Unchanged when both or neither are accepted.
  - full, almostFull and almostEmpty are registered and derived from the post-edge count.
- Simultaneous events:
  - Full with read+write: the read is accepted, the write is rejected (writeError pulses); count becomes DEPTH-1.
  - empty=1 with read+write: the write is accepted, the read is rejected (readError pulses).
  - Otherwise both are accepted and count holds.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no bubble. Full and empty are distinguished by count, not by pointer equality.
- FWFT=1:
  - A word written at edge k into an empty FIFO appears on readData with empty=0 after edge k+2 (RAM read plus output register).
  - readEnable with empty=0 pops the presented word. The next word is presented after the following edge if available; otherwise empty=1 after that edge.
  - Back-to-back reads sustain 1 word per cycle.
  - readData holds its last value while empty=1.
- FWFT=0:
  - A word written at edge k makes empty=0 after edge k+1.
  - A read accepted at edge r places its word on readData after edge r+1.
  - readData holds between reads.
- empty vs count:
  - empty reflects read-side availability and may lag count by the FWFT prefetch latency.
  - count is always the architectural occupancy.
- Ordering: strict FIFO ordering with no data corruption at any occupancy.
- Elaboration errors:
  - ALMOST_FULL_OFFSET >= DEPTH is an elaboration error.
  - ALMOST_EMPTY_OFFSET >= DEPTH is an elaboration error.
  - DEPTH_LOG2 < 2 is an elaboration error.

Test Plan:
- Reset then idle 5 cycles -> empty=1, almostEmpty=1, full=0, count=0, readData=0, no error pulses.
- FWFT=1: write 0x000000ABC at edge k -> empty=0 and readData=0x000000ABC after edge k+2. Pulse readEnable -> empty=1 next cycle, count=0.
- DEPTH_LOG2=4: write 16 words 0..15 -> full=1, count=16, almostFull set at count 16-OFFSET. Write a 17th word -> writeError one cycle, count stays 16. Read all 16 -> values 0..15 in order.
- Empty FIFO with readEnable=1 -> readError one cycle, count=0. Full FIFO with read+write in the same cycle -> count=15, writeError=1, read word = oldest.
- Steady state at count=8 with read+write every cycle for 100 cycles (pointers wrap 6+ times) -> count stays 8, no gaps or errors, output sequence equals input sequence.
- FWFT=0: write 0x5 at edge k -> empty=0 after k+1. Read at edge r -> readData=0x5 after r+1. Then assert reset with count=5 -> all outputs return to reset values next cycle.
